// File: rtl/sm_mult_seq.sv
// Iterative sign-magnitude multiplier retiring two multiplier bits per cycle (radix-4).
// Define SM_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier magnitude is zero.
module sm_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 busy
);

  localparam int PW   = 2 * WIDTH;
  localparam int HALF = WIDTH / 2;
  localparam int KW   = $clog2(HALF + 1);
  localparam logic [KW-1:0] K_LAST = KW'(HALF);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mag_a_q, mag_a_d;
  logic [WIDTH-1:0]  mag_b_q, mag_b_d;
  logic              sign_q, sign_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [KW-1:0]     k_q, k_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [PW-1:0]     out_q, out_d;
  logic              busy_q, busy_d;

  logic [PW-1:0]     pp_s;
  logic [KW:0]       shamt_s;
  logic              finish_s;

  // Radix-4 partial product: the magnitude times one base-4 digit of the multiplier.
  function automatic logic [PW-1:0] radix4_pp(input logic [WIDTH-1:0] a, input logic [1:0] digit);
    logic [PW-1:0] a_ext;
    a_ext = {{WIDTH{1'b0}}, a};
    case (digit)
      2'd0:    radix4_pp = {PW{1'b0}};
      2'd1:    radix4_pp = a_ext;
      2'd2:    radix4_pp = a_ext << 1;
      default: radix4_pp = a_ext + (a_ext << 1);
    endcase
  endfunction

  assign pp_s    = radix4_pp(mag_a_q, mag_b_q[1:0]);
  assign shamt_s = {k_q, 1'b0};

  // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d     = state_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    sign_d      = sign_q;
    acc_d       = acc_q;
    k_d         = k_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    busy_d      = busy_q;
    finish_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mag_a_d    = {1'b0, A[WIDTH-2:0]};
          mag_b_d    = {1'b0, B[WIDTH-2:0]};
          sign_d     = A[WIDTH-1] ^ B[WIDTH-1];
          acc_d      = {PW{1'b0}};
          k_d        = {KW{1'b0}};
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_BUSY;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_BUSY: begin
        acc_d   = acc_q + (pp_s << shamt_s);
        mag_b_d = mag_b_q >> 2'd2;
        k_d     = k_q + K_ONE;
`ifdef SM_MULT_EARLY_EXIT_EN
        finish_s = (k_d == K_LAST) || (mag_b_d == {WIDTH{1'b0}});
`else
        finish_s = (k_d == K_LAST);
`endif
        if (finish_s) begin
          // A zero magnitude always leaves as +0, even for -0 operands.
          out_d       = {sign_q & (acc_d != {PW{1'b0}}), acc_d[PW-2:0]};
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          state_d     = S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d     = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mag_a_q     <= {WIDTH{1'b0}};
      mag_b_q     <= {WIDTH{1'b0}};
      sign_q      <= 1'b0;
      acc_q       <= {PW{1'b0}};
      k_q         <= {KW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= {PW{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      sign_q      <= sign_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = busy_q;

endmodule
